// File: rtl/arm_pkg.sv
// ----------------------------------------------------------------------------
// arm_pkg
// Shared definitions for the ARMv4T banked register file:
//   - processor mode encodings (CPSR[4:0])
//   - CPSR bit positions (N, Z, C, V, I, F, T, MODE)
//   - CPSR reset value
//   - physical GPR index constants for the banked copies
//   - small helpers classifying mode encodings
// ----------------------------------------------------------------------------
package arm_pkg;

  typedef enum logic [4:0] {
    MODE_USR = 5'h10,
    MODE_FIQ = 5'h11,
    MODE_IRQ = 5'h12,
    MODE_SVC = 5'h13,
    MODE_ABT = 5'h17,
    MODE_UND = 5'h1B,
    MODE_SYS = 5'h1F
  } arm_mode_e;

  localparam int CPSR_N       = 31;
  localparam int CPSR_Z       = 30;
  localparam int CPSR_C       = 29;
  localparam int CPSR_V       = 28;
  localparam int CPSR_I       = 7;
  localparam int CPSR_F       = 6;
  localparam int CPSR_T       = 5;
  localparam int CPSR_MODE_HI = 4;
  localparam int CPSR_MODE_LO = 0;

  localparam logic [31:0] CPSR_RESET = 32'hD3;

  // Physical layout: 0-15 base bank (r15 lives at 15 for every mode),
  // 16-22 FIQ r8-r14, then r13/r14 pairs for IRQ, SVC, ABT, UND.
  localparam logic [4:0] PHYS_FIQ_R8  = 5'd16;
  localparam logic [4:0] PHYS_IRQ_R13 = 5'd23;
  localparam logic [4:0] PHYS_SVC_R13 = 5'd25;
  localparam logic [4:0] PHYS_ABT_R13 = 5'd27;
  localparam logic [4:0] PHYS_UND_R13 = 5'd29;

  localparam int NUM_PHYS = 31;
  localparam int NUM_SPSR = 5;

  // Encodings the CPSR mode field may hold.
  function automatic logic mode_legal(input logic [4:0] m);
    case (m)
      MODE_USR, MODE_FIQ, MODE_IRQ, MODE_SVC,
      MODE_ABT, MODE_UND, MODE_SYS: return 1'b1;
      default:                      return 1'b0;
    endcase
  endfunction

  // Exception modes own an SPSR; USR and SYS do not.
  function automatic logic mode_has_spsr(input logic [4:0] m);
    case (m)
      MODE_FIQ, MODE_IRQ, MODE_SVC, MODE_ABT, MODE_UND: return 1'b1;
      default:                                          return 1'b0;
    endcase
  endfunction

  // SPSR storage slot for an exception mode.
  function automatic logic [2:0] spsr_slot(input logic [4:0] m);
    case (m)
      MODE_FIQ: return 3'd0;
      MODE_IRQ: return 3'd1;
      MODE_SVC: return 3'd2;
      MODE_ABT: return 3'd3;
      MODE_UND: return 3'd4;
      default:  return 3'd0;
    endcase
  endfunction

endpackage

// File: rtl/banked_regfile_if.sv
// ----------------------------------------------------------------------------
// banked_regfile_if
// Operand-fetch / write-back / PSR bus of the banked register file.
//   master : decode + execute side (drives addresses, write data, strobes)
//   slave  : the register file (drives rd_data, cpsr, spsr)
// Signals: rd_addr/rd_data (NUM_RD flattened ports), wr_en/wr_addr/wr_data,
// flag_we/flags_in, psr_we/psr_sel/psr_mask/psr_data, exc_req/exc_mode/
// exc_lr, exc_ret, cpsr, spsr.
// ----------------------------------------------------------------------------
interface banked_regfile_if #(
  parameter int DATA_W = 32,
  parameter int NUM_RD = 3
);
  logic [NUM_RD*4-1:0]      rd_addr;
  logic [NUM_RD*DATA_W-1:0] rd_data;
  logic                     wr_en;
  logic [3:0]               wr_addr;
  logic [DATA_W-1:0]        wr_data;
  logic                     flag_we;
  logic [3:0]               flags_in;
  logic                     psr_we;
  logic                     psr_sel;
  logic [3:0]               psr_mask;
  logic [DATA_W-1:0]        psr_data;
  logic                     exc_req;
  logic [4:0]               exc_mode;
  logic [DATA_W-1:0]        exc_lr;
  logic                     exc_ret;
  logic [31:0]              cpsr;
  logic [31:0]              spsr;

  modport master (
    output rd_addr, wr_en, wr_addr, wr_data, flag_we, flags_in,
           psr_we, psr_sel, psr_mask, psr_data,
           exc_req, exc_mode, exc_lr, exc_ret,
    input  rd_data, cpsr, spsr
  );

  modport slave (
    input  rd_addr, wr_en, wr_addr, wr_data, flag_we, flags_in,
           psr_we, psr_sel, psr_mask, psr_data,
           exc_req, exc_mode, exc_lr, exc_ret,
    output rd_data, cpsr, spsr
  );
endinterface

// File: rtl/banked_regfile_bank_map.sv
// ----------------------------------------------------------------------------
// bank_map
// Combinational translation of (processor mode, architectural register) to a
// physical GPR index.
//   i_mode : CPSR mode field
//   i_arch : architectural register number r0-r15
//   o_phys : physical index 0-30
// Unknown mode encodings fall back to the base bank.
// ----------------------------------------------------------------------------
module bank_map
  import arm_pkg::*;
(
  input  logic [4:0] i_mode,
  input  logic [3:0] i_arch,
  output logic [4:0] o_phys
);
  logic       w_fiq_hi;
  logic       w_sp_lr;
  logic [4:0] w_lr_ofs;

  assign w_fiq_hi = (i_arch >= 4'd8) && (i_arch <= 4'd14);
  assign w_sp_lr  = (i_arch == 4'd13) || (i_arch == 4'd14);
  // r13 sits at the pair's base index, r14 one above it.
  assign w_lr_ofs = {4'b0, (i_arch == 4'd14)};

  always_comb begin
    o_phys = {1'b0, i_arch};
    if (i_mode == MODE_FIQ && w_fiq_hi) begin
      o_phys = PHYS_FIQ_R8 + {1'b0, i_arch - 4'd8};
    end else if (w_sp_lr) begin
      case (i_mode)
        MODE_IRQ: o_phys = PHYS_IRQ_R13 + w_lr_ofs;
        MODE_SVC: o_phys = PHYS_SVC_R13 + w_lr_ofs;
        MODE_ABT: o_phys = PHYS_ABT_R13 + w_lr_ofs;
        MODE_UND: o_phys = PHYS_UND_R13 + w_lr_ofs;
        default:  ;
      endcase
    end
  end
endmodule

// File: rtl/banked_regfile.sv
// ----------------------------------------------------------------------------
// banked_regfile
// ARMv4T register file: 31 physical GPRs banked by mode, CPSR, five SPSRs,
// exception entry (exc_req) and exception return (exc_ret).
//   clock : rising-edge clock
//   reset : synchronous active-high reset
//   bus   : banked_regfile_if.slave (read ports, write-back, flags, MSR,
//           exception controls, cpsr/spsr outputs)
// Parameters: DATA_W (>= 32), NUM_RD (read ports).
// Build option: define REGFILE_BYPASS_EN to forward same-cycle write data to
// matching read ports; otherwise reads return the stored value.
// ----------------------------------------------------------------------------
module banked_regfile
  import arm_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int NUM_RD = 3
) (
  input  logic           clock,
  input  logic           reset,
  banked_regfile_if.slave bus
);
  logic [DATA_W-1:0] r_gpr  [NUM_PHYS];
  logic [DATA_W-1:0] r_spsr [NUM_SPSR];
  logic [DATA_W-1:0] r_cpsr;

  logic [4:0]        w_mode;
  logic              w_cur_has_spsr;
  logic [DATA_W-1:0] w_spsr_cur;
  logic [4:0]        w_wr_map_mode;
  logic [3:0]        w_wr_map_arch;
  logic [4:0]        w_wr_phys;
  logic [4:0]        w_rd_phys [NUM_RD];
  logic [3:0]        w_psr_mask_eff;

  logic [DATA_W-1:0] w_cpsr_next;
  logic              w_gpr_we;
  logic [DATA_W-1:0] w_gpr_wdata;
  logic              w_spsr_we;
  logic [2:0]        w_spsr_slot;
  logic [DATA_W-1:0] w_spsr_next;

  assign w_mode         = r_cpsr[CPSR_MODE_HI:CPSR_MODE_LO];
  assign w_cur_has_spsr = mode_has_spsr(w_mode);
  assign w_spsr_cur     = r_spsr[spsr_slot(w_mode)];
  // USR may only touch the flags byte.
  assign w_psr_mask_eff = (w_mode == MODE_USR) ? (bus.psr_mask & 4'b1000)
                                               : bus.psr_mask;

  // The write-port mapper is shared: during exception entry it targets the
  // new mode's r14 instead of the write-back destination.
  assign w_wr_map_mode = bus.exc_req ? bus.exc_mode : w_mode;
  assign w_wr_map_arch = bus.exc_req ? 4'd14 : bus.wr_addr;

  bank_map u_wr_map (
    .i_mode (w_wr_map_mode),
    .i_arch (w_wr_map_arch),
    .o_phys (w_wr_phys)
  );

  for (genvar gi = 0; gi < NUM_RD; gi++) begin : g_rd
    bank_map u_rd_map (
      .i_mode (w_mode),
      .i_arch (bus.rd_addr[4*gi +: 4]),
      .o_phys (w_rd_phys[gi])
    );
`ifdef REGFILE_BYPASS_EN
    assign bus.rd_data[DATA_W*gi +: DATA_W] =
      (bus.wr_en && !bus.exc_req && (w_rd_phys[gi] == w_wr_phys))
        ? bus.wr_data : r_gpr[w_rd_phys[gi]];
`else
    assign bus.rd_data[DATA_W*gi +: DATA_W] = r_gpr[w_rd_phys[gi]];
`endif
  end

  assign bus.cpsr = r_cpsr[31:0];
  assign bus.spsr = w_cur_has_spsr ? w_spsr_cur[31:0] : 32'h0;

  // Next-state selection in priority order: exc_req > exc_ret > psr_we >
  // flag_we. wr_en survives everything except exc_req.
  always_comb begin
    w_cpsr_next = r_cpsr;
    w_gpr_we    = 1'b0;
    w_gpr_wdata = bus.wr_data;
    w_spsr_we   = 1'b0;
    w_spsr_slot = spsr_slot(w_mode);
    w_spsr_next = w_spsr_cur;

    if (bus.exc_req) begin
      w_gpr_we    = 1'b1;
      w_gpr_wdata = bus.exc_lr;
      w_spsr_we   = mode_has_spsr(bus.exc_mode);
      w_spsr_slot = spsr_slot(bus.exc_mode);
      w_spsr_next = r_cpsr;
      w_cpsr_next[CPSR_MODE_HI:CPSR_MODE_LO] = bus.exc_mode;
      w_cpsr_next[CPSR_T] = 1'b0;
      w_cpsr_next[CPSR_I] = 1'b1;
      if (bus.exc_mode == MODE_FIQ) w_cpsr_next[CPSR_F] = 1'b1;
    end else begin
      w_gpr_we = bus.wr_en;
      if (bus.exc_ret && w_cur_has_spsr) begin
        w_cpsr_next = w_spsr_cur;
      end else begin
        if (bus.flag_we) w_cpsr_next[CPSR_N:CPSR_V] = bus.flags_in;
        if (bus.psr_we && !bus.psr_sel) begin
          // Applied after the flag load so an MSR to the f byte wins.
          for (int b = 0; b < 4; b++) begin
            if (w_psr_mask_eff[b]) w_cpsr_next[8*b +: 8] = bus.psr_data[8*b +: 8];
          end
          if (w_psr_mask_eff[0] && !mode_legal(bus.psr_data[4:0]))
            w_cpsr_next[7:0] = r_cpsr[7:0];
        end else if (bus.psr_we && bus.psr_sel && w_cur_has_spsr) begin
          w_spsr_we = 1'b1;
          for (int b = 0; b < 4; b++) begin
            if (w_psr_mask_eff[b]) w_spsr_next[8*b +: 8] = bus.psr_data[8*b +: 8];
          end
        end
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < NUM_PHYS; i++) r_gpr[i] <= '0;
      for (int i = 0; i < NUM_SPSR; i++) r_spsr[i] <= '0;
      r_cpsr <= DATA_W'(CPSR_RESET);
    end else begin
      if (w_gpr_we)  r_gpr[w_wr_phys]    <= w_gpr_wdata;
      if (w_spsr_we) r_spsr[w_spsr_slot] <= w_spsr_next;
      r_cpsr <= w_cpsr_next;
    end
  end
endmodule
